// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage stall/jump requests in,
// stall/flush/redirect and perf counters out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             if_stall_req;
  logic             id_stall_req;
  logic             mem_stall_req;
  logic             ex_jump;
  logic [31:0]      ex_jump_addr;
  logic             if_ack;
  logic [5:0]       stall;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_addr;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_stall_req, id_stall_req,
    output mem_stall_req, ex_jump,
    output ex_jump_addr, if_ack,
    input  stall, flush,
    input  redirect_valid, redirect_addr,
    input  cyc_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_stall_req, id_stall_req,
    input  mem_stall_req, ex_jump,
    input  ex_jump_addr, if_ack,
    output stall, flush,
    output redirect_valid, redirect_addr,
    output cyc_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control: stall vector, jump flush,
// held PC redirect for IF, and performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Stall vector: the deepest requesting stage wins
  always_comb begin
    bus.stall = 6'b000000;
    if (bus.mem_stall_req)
      bus.stall = 6'b011111;
    else if (bus.id_stall_req)
      bus.stall = 6'b000111;
    else if (bus.if_stall_req)
      bus.stall = 6'b000011;
  end

  // A jump is only taken when EX is not frozen
  always_comb begin
    accept   = bus.ex_jump && !bus.stall[3];
    bus.flush = accept;
  end

  // Redirect next state: newest accepted jump wins
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = PEND;
      PEND: begin
        if (accept)
          state_nxt = PEND;
        else if (bus.if_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Redirect state and target register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        addr_q <= bus.ex_jump_addr;
    end
  end

  // Free-running perf counters, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (|bus.stall)
        stall_q <= stall_q + 1'b1;
      if (accept)
        flush_q <= flush_q + 1'b1;
    end
  end

  // Drive registered outputs
  always_comb begin
    bus.redirect_valid = (state == PEND);
    bus.redirect_addr  = addr_q;
    bus.cyc_cnt        = cyc_q;
    bus.stall_cnt      = stall_q;
    bus.flush_cnt      = flush_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl,
// plus a 4-bit counter instance for wrap.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_ctrl_if #(.CNT_W(32)) bus ();
  pipe_ctrl_if #(.CNT_W(4))  wbus ();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_ctrl #(.CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    bus.if_stall_req  = 1'b0;
    bus.id_stall_req  = 1'b0;
    bus.mem_stall_req = 1'b0;
    bus.ex_jump       = 1'b0;
    bus.ex_jump_addr  = 32'h0;
    bus.if_ack        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_in();
    wbus.if_stall_req  = 1'b0;
    wbus.id_stall_req  = 1'b0;
    wbus.mem_stall_req = 1'b0;
    wbus.ex_jump       = 1'b0;
    wbus.ex_jump_addr  = 32'h0;
    wbus.if_ack        = 1'b0;
    bus.mem_stall_req  = 1'b1;
    bus.ex_jump        = 1'b1;
    #2;
    checks++;
    if (bus.stall !== 6'b011111) begin
      errors++;
      $display("FAIL rst_stall got=%b exp=011111", bus.stall);
    end
    checks++;
    if (bus.cyc_cnt !== 32'd0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_state cyc=%0d rv=%b exp=0/0",
               bus.cyc_cnt, bus.redirect_valid);
    end
    bus.mem_stall_req = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL rst_flush got=%b exp=1", bus.flush);
    end
    idle_in();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cyc_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rst_cyc1 got=%0d exp=1", bus.cyc_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.if_stall_req  = 1'b1;
    bus.id_stall_req  = 1'b1;
    bus.mem_stall_req = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 6'b011111) begin
      errors++;
      $display("FAIL prio_mem got=%b exp=011111", bus.stall);
    end
    @(negedge clk);
    bus.mem_stall_req = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 6'b000111) begin
      errors++;
      $display("FAIL prio_id got=%b exp=000111", bus.stall);
    end
    @(negedge clk);
    bus.id_stall_req = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 6'b000011) begin
      errors++;
      $display("FAIL prio_if got=%b exp=000011", bus.stall);
    end
    @(negedge clk);
    bus.if_stall_req = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("FAIL prio_none got=%b exp=000000", bus.stall);
    end
    checks++;
    if (bus.stall_cnt !== 32'd3 || bus.cyc_cnt !== 32'd3) begin
      errors++;
      $display("FAIL prio_cnt stall=%0d cyc=%0d exp=3/3",
               bus.stall_cnt, bus.cyc_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ex_jump      = 1'b1;
    bus.ex_jump_addr = 32'h0000_1040;
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush fl=%b rv=%b exp=1/0",
               bus.flush, bus.redirect_valid);
    end
    @(negedge clk);
    bus.ex_jump      = 1'b0;
    bus.ex_jump_addr = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b1 ||
        bus.redirect_addr !== 32'h0000_1040) begin
      errors++;
      $display("FAIL redir_pend fl=%b rv=%b a=%h exp=0/1/1040",
               bus.flush, bus.redirect_valid, bus.redirect_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_hold got=%b exp=1", bus.redirect_valid);
    end
    bus.if_ack = 1'b1;
    @(negedge clk);
    bus.if_ack = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL redir_ack rv=%b fc=%0d exp=0/1",
               bus.redirect_valid, bus.flush_cnt);
    end
    bus.if_ack = 1'b1;
    @(negedge clk);
    bus.if_ack = 1'b0;
    checks++;
    if (bus.redirect_valid !== 1'b0 ||
        bus.redirect_addr !== 32'h0000_1040) begin
      errors++;
      $display("FAIL redir_idle_ack rv=%b a=%h exp=0/1040",
               bus.redirect_valid, bus.redirect_addr);
    end
  endtask

  task automatic test_frozen();
    do_reset();
    bus.mem_stall_req = 1'b1;
    bus.ex_jump       = 1'b1;
    bus.ex_jump_addr  = 32'h0000_0200;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.stall !== 6'b011111) begin
      errors++;
      $display("FAIL frz_c0 fl=%b st=%b exp=0/011111",
               bus.flush, bus.stall);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL frz_hold rv=%b fc=%0d exp=0/0",
               bus.redirect_valid, bus.flush_cnt);
    end
    bus.mem_stall_req = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL frz_rel fl=%b exp=1", bus.flush);
    end
    @(negedge clk);
    bus.ex_jump = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b1 ||
        bus.redirect_addr !== 32'h0000_0200 ||
        bus.flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL frz_pend rv=%b a=%h fc=%0d exp=1/200/1",
               bus.redirect_valid, bus.redirect_addr, bus.flush_cnt);
    end
  endtask

  task automatic test_id_jump();
    do_reset();
    bus.id_stall_req = 1'b1;
    bus.ex_jump      = 1'b1;
    bus.ex_jump_addr = 32'h0000_0044;
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.stall !== 6'b000111) begin
      errors++;
      $display("FAIL idj fl=%b st=%b exp=1/000111",
               bus.flush, bus.stall);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b1 ||
        bus.redirect_addr !== 32'h0000_0044 ||
        bus.stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL idj_pend rv=%b a=%h sc=%0d exp=1/44/1",
               bus.redirect_valid, bus.redirect_addr, bus.stall_cnt);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    bus.ex_jump      = 1'b1;
    bus.ex_jump_addr = 32'h0000_0100;
    @(negedge clk);
    bus.ex_jump = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b1 ||
        bus.redirect_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL ovw_first rv=%b a=%h exp=1/100",
               bus.redirect_valid, bus.redirect_addr);
    end
    bus.if_ack       = 1'b1;
    bus.ex_jump      = 1'b1;
    bus.ex_jump_addr = 32'h0000_0300;
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b1 ||
        bus.redirect_addr !== 32'h0000_0300 ||
        bus.flush_cnt !== 32'd2) begin
      errors++;
      $display("FAIL ovw rv=%b a=%h fc=%0d exp=1/300/2",
               bus.redirect_valid, bus.redirect_addr, bus.flush_cnt);
    end
  endtask

  task automatic test_reset_pend();
    do_reset();
    bus.ex_jump      = 1'b1;
    bus.ex_jump_addr = 32'h0000_0ABC;
    bus.if_stall_req = 1'b1;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.cyc_cnt !== 32'd2 ||
        bus.stall_cnt !== 32'd1 || bus.flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rp_pre rv=%b c=%0d s=%0d f=%0d exp=1/2/1/1",
               bus.redirect_valid, bus.cyc_cnt,
               bus.stall_cnt, bus.flush_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h0 ||
        bus.cyc_cnt !== 32'd0 || bus.stall_cnt !== 32'd0 ||
        bus.flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rp_async rv=%b a=%h c=%0d s=%0d f=%0d exp=0",
               bus.redirect_valid, bus.redirect_addr, bus.cyc_cnt,
               bus.stall_cnt, bus.flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cyc_cnt !== 32'd1 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_rel c=%0d rv=%b exp=1/0",
               bus.cyc_cnt, bus.redirect_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (wbus.cyc_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_15 got=%0d exp=15", wbus.cyc_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wbus.cyc_cnt !== 4'd0 || bus.cyc_cnt !== 32'd16) begin
      errors++;
      $display("FAIL wrap_0 w=%0d n=%0d exp=0/16",
               wbus.cyc_cnt, bus.cyc_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_priority();
    test_redirect();
    test_frozen();
    test_id_jump();
    test_overwrite();
    test_reset_pend();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
